// File: rtl/iomem_sample_fifo_if.sv
// PicoSoC iomem bus bundle used by iomem_sample_fifo.
// The master drives the request and the slave returns ready/rdata.
interface iomem_sample_fifo_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_sample_fifo.sv
// iomem_sample_fifo: CPU-written stereo PCM sample FIFO for i2s_tx.
// Firmware pushes {right,left} words over iomem. Each falling edge of the
// codec DACLRC, after synchronisation, pops one pair into left_chan/right_chan.
// Register map (iomem_addr[3:2]): 0 DATA, 1 STATUS, 2 THRESH, 3 CTRL.
// Optional macro SAMPLE_FIFO_HOLD_LAST_EN: when defined, an underrun keeps
// the last popped pair on the outputs. When undefined, an underrun mutes them.
module iomem_sample_fifo #(
    parameter int         BITSIZE    = 16,
    parameter int         DEPTH_LOG2 = 6,
    parameter logic [7:0] ADDR_PAGE  = 8'h05
) (
    input  logic                clk,
    input  logic                resetn,
    iomem_sample_fifo_if.slave  bus,
    input  logic                lrclk,
    output logic [BITSIZE-1:0]  left_chan,
    output logic [BITSIZE-1:0]  right_chan,
    output logic                irq
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [2*BITSIZE-1:0] mem_r [DEPTH];
    logic [PW-1:0]        wptr_r, rptr_r, thresh_r;
    logic                 en_r, undr_r, ovf_r;
    logic                 lr_sync1_r, lr_sync2_r, lr_prev_r;

    logic [PW-1:0]        level_s;
    logic                 full_s, empty_s, hit_s, wr_s;
    logic [1:0]           sel_s;
    logic                 push_req_s, push_ok_s, pop_s, frame_s;
    logic                 undr_evt_s, ovf_evt_s, flush_s;
    logic                 clr_undr_s, clr_ovf_s;
    logic [31:0]          rd_data_s;
    logic                 unused_addr_s;

    // Pack occupancy and sticky flags into the STATUS register layout.
    function automatic logic [31:0] status_word(input logic [PW-1:0] lvl,
                                                input logic f, input logic e,
                                                input logic u, input logic o);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[PW-1:0] = lvl;
        w[16] = f;
        w[17] = e;
        w[18] = u;
        w[19] = o;
        return w;
    endfunction

    assign unused_addr_s = ^{bus.addr[23:4], bus.addr[1:0]};

    // Decode bus requests, FIFO occupancy and push/pop/flush events.
    always_comb begin
        level_s    = wptr_r - rptr_r;
        empty_s    = (wptr_r == rptr_r);
        full_s     = (wptr_r[PW-1] != rptr_r[PW-1]) &&
                     (wptr_r[PW-2:0] == rptr_r[PW-2:0]);
        hit_s      = bus.valid & ~bus.ready & (bus.addr[31:24] == ADDR_PAGE);
        sel_s      = bus.addr[3:2];
        wr_s       = hit_s & (bus.wstrb != 4'h0);
        push_req_s = hit_s & (sel_s == 2'd0) & (bus.wstrb == 4'hF);
        flush_s    = wr_s & (sel_s == 2'd3) & bus.wstrb[0] & bus.wdata[1];
        clr_undr_s = wr_s & (sel_s == 2'd1) & bus.wstrb[2] & bus.wdata[18];
        clr_ovf_s  = wr_s & (sel_s == 2'd1) & bus.wstrb[2] & bus.wdata[19];
        // Frame event: synchronised lrclk fell while playback is enabled.
        frame_s    = lr_prev_r & ~lr_sync2_r & en_r;
        // Pop sees the pre-cycle state; a flush overrides both directions.
        pop_s      = frame_s & ~empty_s & ~flush_s;
        undr_evt_s = frame_s & empty_s & ~flush_s;
        // Full is judged after this cycle's pop, so a pop frees a slot.
        push_ok_s  = push_req_s & ~flush_s & (~full_s | pop_s);
        ovf_evt_s  = push_req_s & ~flush_s & full_s & ~pop_s;
        rd_data_s  = 32'h0000_0000;
        case (sel_s)
            2'd0:    rd_data_s = 32'h0000_0000;
            2'd1:    rd_data_s = status_word(level_s, full_s, empty_s, undr_r, ovf_r);
            2'd2:    rd_data_s[PW-1:0] = thresh_r;
            2'd3:    rd_data_s = {31'h0000_0000, en_r};
            default: rd_data_s = 32'h0000_0000;
        endcase
    end

    // Sample storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r[DEPTH_LOG2-1:0]] <= {bus.wdata[16+BITSIZE-1:16],
                                              bus.wdata[BITSIZE-1:0]};
        end
    end

    // Bus ack, lrclk synchroniser, pointers, registers, outputs and irq.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.ready  <= 1'b0;
            bus.rdata  <= 32'h0000_0000;
            lr_sync1_r <= 1'b0;
            lr_sync2_r <= 1'b0;
            lr_prev_r  <= 1'b0;
            wptr_r     <= PTR_ZERO;
            rptr_r     <= PTR_ZERO;
            thresh_r   <= PTR_ZERO;
            en_r       <= 1'b0;
            undr_r     <= 1'b0;
            ovf_r      <= 1'b0;
            left_chan  <= {BITSIZE{1'b0}};
            right_chan <= {BITSIZE{1'b0}};
            irq        <= 1'b0;
        end else begin
            bus.ready  <= hit_s;
            bus.rdata  <= hit_s ? rd_data_s : 32'h0000_0000;
            lr_sync1_r <= lrclk;
            lr_sync2_r <= lr_sync1_r;
            lr_prev_r  <= lr_sync2_r;
            if (flush_s) begin
                wptr_r <= PTR_ZERO;
                rptr_r <= PTR_ZERO;
            end else begin
                if (push_ok_s) wptr_r <= wptr_r + PTR_ONE;
                if (pop_s)     rptr_r <= rptr_r + PTR_ONE;
            end
            if (pop_s) begin
                {right_chan, left_chan} <= mem_r[rptr_r[DEPTH_LOG2-1:0]];
            end else if (undr_evt_s) begin
`ifdef SAMPLE_FIFO_HOLD_LAST_EN
                left_chan  <= left_chan;
                right_chan <= right_chan;
`else
                left_chan  <= {BITSIZE{1'b0}};
                right_chan <= {BITSIZE{1'b0}};
`endif
            end
            // A new event wins over a clear issued in the same cycle.
            if (undr_evt_s)      undr_r <= 1'b1;
            else if (clr_undr_s) undr_r <= 1'b0;
            if (ovf_evt_s)       ovf_r  <= 1'b1;
            else if (clr_ovf_s)  ovf_r  <= 1'b0;
            if (wr_s && (sel_s == 2'd2) && bus.wstrb[0]) thresh_r <= bus.wdata[PW-1:0];
            if (wr_s && (sel_s == 2'd3) && bus.wstrb[0]) en_r     <= bus.wdata[0];
            irq <= en_r & (level_s <= thresh_r);
        end
    end
endmodule

// File: tb/tb_iomem_sample_fifo.sv
// Directed self-checking bench for iomem_sample_fifo (default parameters).
module tb_iomem_sample_fifo;
    localparam logic [31:0] A_DATA   = 32'h0500_0000;
    localparam logic [31:0] A_STATUS = 32'h0500_0004;
    localparam logic [31:0] A_THRESH = 32'h0500_0008;
    localparam logic [31:0] A_CTRL   = 32'h0500_000C;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        lrclk = 1'b0;
    logic [15:0] left_chan, right_chan;
    logic        irq;
    int          checks = 0;
    int          failures = 0;

    iomem_sample_fifo_if iomem();

    iomem_sample_fifo #(.BITSIZE(16), .DEPTH_LOG2(6), .ADDR_PAGE(8'h05)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (iomem),
        .lrclk      (lrclk),
        .left_chan  (left_chan),
        .right_chan (right_chan),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata);
        int n;
        @(negedge clk);
        iomem.valid = 1'b1;
        iomem.addr  = addr;
        iomem.wdata = wdata;
        iomem.wstrb = wstrb;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!iomem.ready && n < 4);
        checks++;
        if (iomem.ready !== 1'b1) begin
            failures++;
            $display("FAIL bus_ack addr=%h got ready=%b want 1", addr, iomem.ready);
        end
        rdata = iomem.rdata;
        @(negedge clk);
        iomem.valid = 1'b0;
        iomem.wstrb = 4'h0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb);
        logic [31:0] dummy;
        bus_xfer(addr, wdata, wstrb, dummy);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata);
        bus_xfer(addr, 32'h0, 4'h0, rdata);
    endtask

    task automatic lr_rise();
        @(negedge clk); #1 lrclk = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic lr_frame();
        lr_rise();
        @(negedge clk); #1 lrclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({left_chan, right_chan, irq, iomem.ready} !== 34'h0) begin
            failures++;
            $display("FAIL reset_outputs got l=%h r=%h irq=%b rdy=%b want all 0",
                     left_chan, right_chan, irq, iomem.ready);
        end
        @(negedge clk); resetn = 1'b1;
        // Off-page access must never be acknowledged.
        @(negedge clk);
        iomem.valid = 1'b1; iomem.addr = 32'h0600_0004; iomem.wstrb = 4'h0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (iomem.ready !== 1'b0) begin
            failures++;
            $display("FAIL offpage_ack got ready=%b want 0", iomem.ready);
        end
        @(negedge clk);
        iomem.addr = A_STATUS;
        #1;
        checks++;
        if (iomem.ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_early got %b want 0", iomem.ready);
        end
        @(posedge clk); #1;
        checks++;
        if (iomem.ready !== 1'b1 || iomem.rdata !== 32'h0002_0000) begin
            failures++;
            $display("FAIL reset_status got ready=%b rdata=%h want 1 00020000",
                     iomem.ready, iomem.rdata);
        end
        @(negedge clk); iomem.valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (iomem.ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_one_cycle got %b want 0", iomem.ready);
        end
    endtask

    task automatic test_pop_order();
        logic [31:0] rd;
        logic [15:0] exp_l [2];
        logic [15:0] exp_r [2];
        exp_l[0] = 16'hABCD; exp_r[0] = 16'h1234;
        exp_l[1] = 16'h0002; exp_r[1] = 16'h0001;
        bus_write(A_CTRL, 32'h1, 4'hF);
        bus_write(A_DATA, 32'h1234_ABCD, 4'hF);
        bus_write(A_DATA, 32'h0001_0002, 4'hF);
        bus_write(A_DATA, 32'h5555_6666, 4'h3);
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0000_0002) begin
            failures++;
            $display("FAIL level_two got %h want 00000002", rd);
        end
        for (int i = 0; i < 2; i++) begin
            lr_rise();
            @(negedge clk); #1 lrclk = 1'b0;
            repeat (2) @(posedge clk); #1;
            checks++;
            if (left_chan !== ((i == 0) ? 16'h0000 : exp_l[0])) begin
                failures++;
                $display("FAIL pop_latency_early frame=%0d got l=%h", i, left_chan);
            end
            @(posedge clk); #1;
            checks++;
            if (left_chan !== exp_l[i] || right_chan !== exp_r[i]) begin
                failures++;
                $display("FAIL pop_value frame=%0d got l=%h r=%h want l=%h r=%h",
                         i, left_chan, right_chan, exp_l[i], exp_r[i]);
            end
            bus_read(A_STATUS, rd);
            checks++;
            if (rd !== ((i == 0) ? 32'h0000_0001 : 32'h0002_0000)) begin
                failures++;
                $display("FAIL pop_level frame=%0d got %h", i, rd);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        bus_write(A_CTRL, 32'h0, 4'hF);
        for (int i = 0; i < 65; i++) begin
            bus_write(A_DATA, {16'(16'h0100 + i), 16'(i)}, 4'hF);
        end
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0009_0040) begin
            failures++;
            $display("FAIL ovf_status got %h want 00090040", rd);
        end
        bus_write(A_STATUS, 32'h0008_0000, 4'h4);
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0001_0040) begin
            failures++;
            $display("FAIL ovf_clear got %h want 00010040", rd);
        end
        bus_write(A_CTRL, 32'h1, 4'hF);
        lr_frame();
        checks++;
        if (left_chan !== 16'h0000 || right_chan !== 16'h0100) begin
            failures++;
            $display("FAIL drain_first got l=%h r=%h want 0000 0100", left_chan, right_chan);
        end
        for (int i = 1; i < 64; i++) lr_frame();
        checks++;
        if (left_chan !== 16'h003F || right_chan !== 16'h013F) begin
            failures++;
            $display("FAIL drain_last got l=%h r=%h want 003f 013f", left_chan, right_chan);
        end
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0002_0000) begin
            failures++;
            $display("FAIL drain_empty got %h want 00020000", rd);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] rd;
        logic [15:0] want_l, want_r;
`ifdef SAMPLE_FIFO_HOLD_LAST_EN
        want_l = 16'h003F; want_r = 16'h013F;
`else
        want_l = 16'h0000; want_r = 16'h0000;
`endif
        lr_frame();
        checks++;
        if (left_chan !== want_l || right_chan !== want_r) begin
            failures++;
            $display("FAIL underrun_out got l=%h r=%h want l=%h r=%h",
                     left_chan, right_chan, want_l, want_r);
        end
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0006_0000) begin
            failures++;
            $display("FAIL underrun_flag got %h want 00060000", rd);
        end
        bus_write(A_STATUS, 32'h0004_0000, 4'h4);
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0002_0000) begin
            failures++;
            $display("FAIL underrun_clear got %h want 00020000", rd);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        bus_write(A_THRESH, 32'h4, 4'hF);
        bus_read(A_THRESH, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin
            failures++;
            $display("FAIL thresh_rd got %h want 00000004", rd);
        end
        for (int i = 0; i < 5; i++) begin
            bus_write(A_DATA, {16'(16'hB000 + i), 16'(16'hA000 + i)}, 4'hF);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_level5 got %b want 0", irq);
        end
        lr_rise();
        @(negedge clk); #1 lrclk = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0 || left_chan !== 16'hA000 || right_chan !== 16'hB000) begin
            failures++;
            $display("FAIL irq_pop_edge got irq=%b l=%h r=%h want 0 a000 b000",
                     irq, left_chan, right_chan);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_level4 got %b want 1", irq);
        end
        bus_write(A_CTRL, 32'h3, 4'hF);
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0002_0000 || irq !== 1'b1 || left_chan !== 16'hA000) begin
            failures++;
            $display("FAIL flush got status=%h irq=%b l=%h want 00020000 1 a000",
                     rd, irq, left_chan);
        end
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            failures++;
            $display("FAIL ctrl_rd got %h want 00000001", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        bus_write(A_DATA, 32'h1111_0001, 4'hF);
        bus_write(A_DATA, 32'h2222_0002, 4'hF);
        bus_write(A_DATA, 32'h3333_0003, 4'hF);
        lr_rise();
        @(negedge clk); #1 lrclk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        iomem.valid = 1'b1; iomem.addr = A_DATA;
        iomem.wdata = 32'h4444_0004; iomem.wstrb = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (iomem.ready !== 1'b1 || left_chan !== 16'h0001 || right_chan !== 16'h1111) begin
            failures++;
            $display("FAIL b2b_pop got rdy=%b l=%h r=%h want 1 0001 1111",
                     iomem.ready, left_chan, right_chan);
        end
        @(negedge clk); iomem.valid = 1'b0; iomem.wstrb = 4'h0;
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin
            failures++;
            $display("FAIL b2b_level got %h want 00000003", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        @(negedge clk); #1 resetn = 1'b0;
        #1;
        checks++;
        if (left_chan !== 16'h0 || right_chan !== 16'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL midreset_out got l=%h r=%h irq=%b want 0 0 0",
                     left_chan, right_chan, irq);
        end
        @(negedge clk); resetn = 1'b1;
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0002_0000) begin
            failures++;
            $display("FAIL midreset_status got %h want 00020000", rd);
        end
    endtask

    initial begin
        iomem.valid = 1'b0;
        iomem.wstrb = 4'h0;
        iomem.addr  = 32'h0;
        iomem.wdata = 32'h0;
        test_reset();
        test_pop_order();
        test_overflow();
        test_underrun();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
